// File: rtl/fir_coeff_reload_ctrl.sv
// Reload-stream forwarder and config-packet generator for a reloadable multi-channel FIR.
// aresetn asserts asynchronously; its release is expected to be synchronised to aclk upstream.
module fir_coeff_reload_ctrl #(
  parameter int RELOAD_WIDTH = 16,
  parameter int CFG_WIDTH    = 8,
  parameter int SEL_WIDTH    = 4,
  parameter int NUM_CH       = 1,
  parameter int NUM_COEFFS   = 64
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_CH*SEL_WIDTH-1:0] coeff_sel,

  input  logic [RELOAD_WIDTH-1:0]     s_reload_tdata,
  input  logic                        s_reload_tvalid,
  input  logic                        s_reload_tlast,
  output logic                        s_reload_tready,

  output logic [RELOAD_WIDTH-1:0]     m_reload_tdata,
  output logic                        m_reload_tvalid,
  output logic                        m_reload_tlast,
  input  logic                        m_reload_tready,

  output logic [CFG_WIDTH-1:0]        m_config_tdata,
  output logic                        m_config_tvalid,
  input  logic                        m_config_tready,

  output logic                        len_err,
  input  logic                        err_clr,
  output logic                        busy
);

  localparam int SEL_TOTAL = NUM_CH * SEL_WIDTH;
  localparam int CNT_W     = $clog2(NUM_COEFFS + 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_EXPECT = CNT_W'(NUM_COEFFS);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(NUM_COEFFS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RELOAD,
    CFG
  } state_t;

  state_t                 state, state_nxt;
  logic [SEL_TOTAL-1:0]   r_sel, r_sel_nxt;
  logic [CNT_W-1:0]       count, count_nxt, count_inc;
  logic                   pending, pending_nxt;
  logic [CFG_WIDTH-1:0]   cfg_tdata_nxt;
  logic                   cfg_tvalid_nxt;
  logic                   len_err_nxt;
  logic                   busy_nxt;
  logic                   len_set;
  logic                   load_cfg;

  logic in_cfg;
  logic beat;
  logic sel_changed;
  logic cfg_hs;

  // Reload path is pure wiring; only the CFG state gates it.
  assign in_cfg          = (state == CFG);
  assign m_reload_tdata  = s_reload_tdata;
  assign m_reload_tlast  = s_reload_tlast;
  assign m_reload_tvalid = s_reload_tvalid & ~in_cfg;
  assign s_reload_tready = m_reload_tready & ~in_cfg;

  assign beat        = s_reload_tvalid & m_reload_tready & ~in_cfg;
  assign sel_changed = (coeff_sel != r_sel);
  assign cfg_hs      = m_config_tvalid & m_config_tready;
  assign count_inc   = (count == CNT_SAT) ? count : count + CNT_ONE;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_nxt      = state;
    r_sel_nxt      = r_sel;
    count_nxt      = count;
    pending_nxt    = pending;
    cfg_tdata_nxt  = m_config_tdata;
    cfg_tvalid_nxt = m_config_tvalid;
    len_set        = 1'b0;
    load_cfg       = 1'b0;

    unique case (state)
      IDLE: begin
        if (beat) begin
          count_nxt = CNT_ONE;
          if (s_reload_tlast) begin
            len_set  = (CNT_ONE != CNT_EXPECT);
            load_cfg = 1'b1;
          end else begin
            state_nxt = RELOAD;
          end
        end else if (sel_changed) begin
          load_cfg = 1'b1;
        end
      end

      RELOAD: begin
        if (sel_changed) pending_nxt = 1'b1;
        if (beat) begin
          count_nxt = count_inc;
          if (s_reload_tlast) begin
            len_set  = (count_inc != CNT_EXPECT);
            load_cfg = 1'b1;
          end
        end
      end

      CFG: begin
        // Valid low while in CFG is the bubble before a re-issued packet.
        if (!m_config_tvalid) begin
          load_cfg = 1'b1;
        end else if (cfg_hs) begin
          cfg_tvalid_nxt = 1'b0;
          if (!(pending || sel_changed)) state_nxt = IDLE;
        end else if (sel_changed) begin
          pending_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Loading a packet always captures the live select so the newest value wins.
    if (load_cfg) begin
      state_nxt      = CFG;
      cfg_tdata_nxt  = CFG_WIDTH'(coeff_sel);
      cfg_tvalid_nxt = 1'b1;
      r_sel_nxt      = coeff_sel;
      pending_nxt    = 1'b0;
    end

    if (len_set)      len_err_nxt = 1'b1;
    else if (err_clr) len_err_nxt = 1'b0;
    else              len_err_nxt = len_err;

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      r_sel           <= '0;
      count           <= '0;
      pending         <= 1'b0;
      m_config_tdata  <= '0;
      m_config_tvalid <= 1'b0;
      len_err         <= 1'b0;
      busy            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state           <= state_nxt;
      r_sel           <= r_sel_nxt;
      count           <= count_nxt;
      pending         <= pending_nxt;
      m_config_tdata  <= cfg_tdata_nxt;
      m_config_tvalid <= cfg_tvalid_nxt;
      len_err         <= len_err_nxt;
      busy            <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_fir_coeff_reload_ctrl.sv
// Scoreboard bench for fir_coeff_reload_ctrl: queued expectations, negedge monitor,
// plus a two-channel instance for packing and asynchronous-reset behaviour.
module tb_fir_coeff_reload_ctrl;
  localparam int RW  = 16;
  localparam int CW  = 8;
  localparam int SW  = 4;
  localparam int NCO = 64;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          aresetn = 1'b0;
  logic [SW-1:0] coeff_sel = '0;
  logic [RW-1:0] s_reload_tdata = '0;
  logic          s_reload_tvalid = 1'b0;
  logic          s_reload_tlast = 1'b0;
  logic          s_reload_tready;
  logic [RW-1:0] m_reload_tdata;
  logic          m_reload_tvalid;
  logic          m_reload_tlast;
  logic          m_reload_tready = 1'b1;
  logic [CW-1:0] m_config_tdata;
  logic          m_config_tvalid;
  logic          m_config_tready = 1'b0;
  logic          len_err;
  logic          err_clr = 1'b0;
  logic          busy;

  fir_coeff_reload_ctrl #(
    .RELOAD_WIDTH(RW), .CFG_WIDTH(CW), .SEL_WIDTH(SW), .NUM_CH(1), .NUM_COEFFS(NCO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .coeff_sel(coeff_sel),
    .s_reload_tdata(s_reload_tdata), .s_reload_tvalid(s_reload_tvalid),
    .s_reload_tlast(s_reload_tlast), .s_reload_tready(s_reload_tready),
    .m_reload_tdata(m_reload_tdata), .m_reload_tvalid(m_reload_tvalid),
    .m_reload_tlast(m_reload_tlast), .m_reload_tready(m_reload_tready),
    .m_config_tdata(m_config_tdata), .m_config_tvalid(m_config_tvalid),
    .m_config_tready(m_config_tready),
    .len_err(len_err), .err_clr(err_clr), .busy(busy)
  );

  // Two-channel instance: SEL_WIDTH=3, NUM_CH=2.
  logic          aresetn_2 = 1'b0;
  logic [5:0]    coeff_sel_2 = 6'b101_010;
  logic [RW-1:0] s_reload_tdata_2 = 16'h1234;
  logic          s_reload_tvalid_2 = 1'b0;
  logic          s_reload_tlast_2 = 1'b0;
  logic          s_reload_tready_2;
  logic [RW-1:0] m_reload_tdata_2;
  logic          m_reload_tvalid_2;
  logic          m_reload_tlast_2;
  logic          m_reload_tready_2 = 1'b1;
  logic [CW-1:0] m_config_tdata_2;
  logic          m_config_tvalid_2;
  logic          m_config_tready_2 = 1'b0;
  logic          len_err_2;
  logic          err_clr_2 = 1'b0;
  logic          busy_2;

  fir_coeff_reload_ctrl #(
    .RELOAD_WIDTH(RW), .CFG_WIDTH(8), .SEL_WIDTH(3), .NUM_CH(2), .NUM_COEFFS(NCO)
  ) dut2 (
    .aclk(aclk), .aresetn(aresetn_2), .coeff_sel(coeff_sel_2),
    .s_reload_tdata(s_reload_tdata_2), .s_reload_tvalid(s_reload_tvalid_2),
    .s_reload_tlast(s_reload_tlast_2), .s_reload_tready(s_reload_tready_2),
    .m_reload_tdata(m_reload_tdata_2), .m_reload_tvalid(m_reload_tvalid_2),
    .m_reload_tlast(m_reload_tlast_2), .m_reload_tready(m_reload_tready_2),
    .m_config_tdata(m_config_tdata_2), .m_config_tvalid(m_config_tvalid_2),
    .m_config_tready(m_config_tready_2),
    .len_err(len_err_2), .err_clr(err_clr_2), .busy(busy_2)
  );

  int checks = 0;
  int failures = 0;

  bit rl_rdy_rand  = 1'b0;
  bit rl_rdy_val   = 1'b1;
  bit cfg_rdy_rand = 1'b0;
  bit cfg_rdy_val  = 1'b0;

  logic [RW:0]   rl_q[$];
  logic [CW-1:0] cfg_q[$];
  logic          exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got=0x%0h at %0t", name, act, $time);
  endtask

  // Sink-side ready generators.
  always @(posedge aclk) begin
    #1;
    m_reload_tready = rl_rdy_rand  ? ($urandom_range(0, 3) != 0) : rl_rdy_val;
    m_config_tready = cfg_rdy_rand ? ($urandom_range(0, 2) != 0) : cfg_rdy_val;
  end

  // Monitor: every handshake pops the next expectation; held config packets must not move.
  logic          cfg_wait = 1'b0;
  logic [CW-1:0] cfg_hold = '0;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (cfg_wait) begin
        check("cfg_tvalid_held", 32'(m_config_tvalid), 32'(1));
        check("cfg_tdata_held", 32'(m_config_tdata), 32'(cfg_hold));
      end
      if (m_config_tvalid) check("reload_stalled_in_cfg", 32'(s_reload_tready), 32'(0));
      if (m_config_tvalid && m_config_tready) begin
        if (cfg_q.size() == 0) fail_now("cfg_unexpected", 32'(m_config_tdata));
        else check("cfg_tdata", 32'(m_config_tdata), 32'(cfg_q.pop_front()));
      end
      if (m_reload_tvalid && m_reload_tready) begin
        if (rl_q.size() == 0) fail_now("reload_unexpected", 32'({m_reload_tlast, m_reload_tdata}));
        else check("reload_beat", 32'({m_reload_tlast, m_reload_tdata}), 32'(rl_q.pop_front()));
      end
      cfg_wait = m_config_tvalid && !m_config_tready;
      cfg_hold = m_config_tdata;
    end else begin
      cfg_wait = 1'b0;
    end
  end

  task automatic wait_accept();
    for (int k = 0; k < 500; k++) begin
      @(negedge aclk);
      if (s_reload_tready) begin
        @(posedge aclk); #1;
        return;
      end
      @(posedge aclk); #1;
    end
    fail_now("reload_accept_timeout", 32'(s_reload_tready));
  endtask

  task automatic wait_idle();
    int k = 0;
    @(posedge aclk);
    @(negedge aclk);
    while ((busy || m_config_tvalid) && k < 1000) begin
      @(negedge aclk);
      k++;
    end
    if (k >= 1000) fail_now("idle_timeout", 32'(busy));
    @(posedge aclk); #1;
  endtask

  // Sends one reload packet of n beats; optionally changes coeff_sel before beat chg_at
  // and holds err_clr high across the whole packet including its tlast beat.
  task automatic send_packet(input int n, input int chg_at, input logic [SW-1:0] chg_val,
                             input bit clr_hold);
    err_clr = clr_hold;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) coeff_sel = chg_val;
      if ($urandom_range(0, 3) == 0) begin
        s_reload_tvalid = 1'b0;
        @(posedge aclk); #1;
      end
      s_reload_tdata  = 16'($urandom);
      s_reload_tlast  = (i == n - 1);
      s_reload_tvalid = 1'b1;
      rl_q.push_back({s_reload_tlast, s_reload_tdata});
      if (i == n - 1) cfg_q.push_back(8'(coeff_sel));
      wait_accept();
    end
    s_reload_tvalid = 1'b0;
    s_reload_tlast  = 1'b0;
    err_clr         = 1'b0;
    if (clr_hold) exp_err = (n != NCO);
    else          exp_err = exp_err | (n != NCO);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge aclk); #1;
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("len_err_cleared", 32'(len_err), 32'(0));
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SW-1:0] new_sel;
    int n;
    int chg;

    // Reset values, with a nonzero select waiting for release.
    coeff_sel = 4'h3;
    cfg_q.push_back(8'h03);
    @(negedge aclk);
    check("rst_cfg_tvalid", 32'(m_config_tvalid), 32'(0));
    check("rst_cfg_tdata", 32'(m_config_tdata), 32'(0));
    check("rst_len_err", 32'(len_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_reload_tready", 32'(s_reload_tready), 32'(1));

    // Release: config 0x03 held through 5 stalled cycles, then one handshake.
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("cfg_valid_while_stalled", 32'(m_config_tvalid), 32'(1));
    end
    cfg_rdy_val = 1'b1;
    @(negedge aclk);
    check("first_cfg_handshake", 32'(m_config_tvalid & m_config_tready), 32'(1));
    cfg_rdy_val = 1'b0;
    @(negedge aclk);
    check("idle_after_cfg_tvalid", 32'(m_config_tvalid), 32'(0));
    check("idle_after_cfg_busy", 32'(busy), 32'(0));

    // Full-length packet with random stalls on both sinks.
    rl_rdy_rand  = 1'b1;
    cfg_rdy_rand = 1'b1;
    @(posedge aclk); #1;
    send_packet(NCO, -1, '0, 1'b0);
    wait_idle();
    check("len_err_ok_64", 32'(len_err), 32'(exp_err));

    // Short then long packet: error set and sticky, then cleared.
    send_packet(63, -1, '0, 1'b0);
    wait_idle();
    check("len_err_short", 32'(len_err), 32'(exp_err));
    send_packet(70, -1, '0, 1'b0);
    wait_idle();
    check("len_err_sticky_long", 32'(len_err), 32'(exp_err));
    clear_err();
    send_packet(NCO, -1, '0, 1'b0);
    wait_idle();
    check("len_err_after_good", 32'(len_err), 32'(exp_err));
    send_packet(1, -1, '0, 1'b0);
    wait_idle();
    check("len_err_single_beat", 32'(len_err), 32'(exp_err));
    clear_err();
    send_packet(65, -1, '0, 1'b1);
    @(negedge aclk);
    check("len_err_set_beats_clr", 32'(len_err), 32'(exp_err));
    wait_idle();
    clear_err();

    // Select change mid-reload: only one config after tlast, carrying the new value.
    coeff_sel = 4'h1;
    cfg_q.push_back(8'h01);
    wait_idle();
    send_packet(NCO, 20, 4'h5, 1'b0);
    wait_idle();
    check("len_err_mid_sel", 32'(len_err), 32'(exp_err));

    // Select change while a config packet is stalled.
    @(negedge aclk);
    rl_rdy_rand  = 1'b0;
    rl_rdy_val   = 1'b1;
    cfg_rdy_rand = 1'b0;
    cfg_rdy_val  = 1'b0;
    @(posedge aclk); #1;
    coeff_sel = 4'h7;
    cfg_q.push_back(8'h07);
    @(posedge aclk);
    repeat (2) @(posedge aclk);
    #1 coeff_sel = 4'h9;
    cfg_q.push_back(8'h09);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("stall_reload_tready", 32'(s_reload_tready), 32'(0));
      check("stall_cfg_tdata", 32'(m_config_tdata), 32'(8'h07));
    end
    cfg_rdy_val = 1'b1;
    @(negedge aclk);
    check("stall_first_hs", 32'(m_config_tvalid & m_config_tready), 32'(1));
    @(negedge aclk);
    check("bubble_tvalid", 32'(m_config_tvalid), 32'(0));
    check("bubble_reload_tready", 32'(s_reload_tready), 32'(0));
    check("bubble_busy", 32'(busy), 32'(1));
    @(negedge aclk);
    check("second_pkt_tvalid", 32'(m_config_tvalid), 32'(1));
    check("second_pkt_tdata", 32'(m_config_tdata), 32'(8'h09));
    @(negedge aclk);
    check("after_second_tvalid", 32'(m_config_tvalid), 32'(0));
    check("after_second_busy", 32'(busy), 32'(0));
    check("after_second_reload_tready", 32'(s_reload_tready), 32'(1));

    // Randomised packets and idle select changes.
    rl_rdy_rand  = 1'b1;
    cfg_rdy_rand = 1'b1;
    @(posedge aclk); #1;
    for (int p = 0; p < 8; p++) begin
      n   = ($urandom_range(0, 2) == 0) ? NCO : int'($urandom_range(60, 68));
      chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 2)) : -1;
      send_packet(n, chg, 4'($urandom), 1'($urandom_range(0, 1)));
      wait_idle();
      check("rand_len_err", 32'(len_err), 32'(exp_err));
      if ($urandom_range(0, 1) == 1) clear_err();
      new_sel = 4'($urandom);
      if (new_sel != coeff_sel) cfg_q.push_back(8'(new_sel));
      coeff_sel = new_sel;
      wait_idle();
    end

    // Two-channel packing and asynchronous reset in CFG.
    @(posedge aclk); #1 aresetn_2 = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("ch2_cfg_tvalid", 32'(m_config_tvalid_2), 32'(1));
    check("ch2_cfg_tdata", 32'(m_config_tdata_2), 32'(8'h2A));
    #2 aresetn_2 = 1'b0;
    #1;
    check("ch2_async_rst_tvalid", 32'(m_config_tvalid_2), 32'(0));
    check("ch2_async_rst_busy", 32'(busy_2), 32'(0));
    coeff_sel_2 = 6'b0;
    @(posedge aclk); #1 aresetn_2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("ch2_no_cfg_after_rst", 32'(m_config_tvalid_2), 32'(0));
      check("ch2_idle_after_rst", 32'(busy_2), 32'(0));
    end

    // Reset mid-reload drops the packet without flagging an error.
    @(posedge aclk); #1 s_reload_tvalid_2 = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("ch2_busy_reloading", 32'(busy_2), 32'(1));
    #2 aresetn_2 = 1'b0;
    #1;
    check("ch2_rst_reload_busy", 32'(busy_2), 32'(0));
    check("ch2_rst_reload_len_err", 32'(len_err_2), 32'(0));
    s_reload_tvalid_2 = 1'b0;
    @(posedge aclk); #1 aresetn_2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("ch2_post_rst_tvalid", 32'(m_config_tvalid_2), 32'(0));
      check("ch2_post_rst_len_err", 32'(len_err_2), 32'(0));
    end

    @(negedge aclk);
    check("cfg_queue_drained", 32'(cfg_q.size()), 32'(0));
    check("reload_queue_drained", 32'(rl_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
